// File: rtl/picobello_tg_launcher.sv
// Picobello traffic-generator launcher.
//
// Drives the AXI4 host port of fpga_picobello_top in place of a host CPU. On an accepted command it
// programs one traffic generator (five config writes), reads the control register, writes the
// start bit (keeping ctrl[7]), then polls the control register until the idle bit ctrl[2] is set.
// Completion is reported with a one-cycle done pulse plus a held error flag and failing step.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   cmd_valid_i/ready_o   command handshake (ready only while idle)
//   cmd_*_i               TG base address, memory base, traffic/compute dims, index
//   axi_req_o/axi_rsp_i   host AXI4 request/response structs
//   busy_o, done_o        busy from acceptance until done; one-cycle completion pulse
//   err_o, err_step_o     status of the last command and the step that failed
//   poll_count_o          idle-poll reads issued by the last command (saturating)

package picobello_tg_launcher_pkg;

  localparam int unsigned HostAddrWidth = 48;
  localparam int unsigned HostDataWidth = 64;
  localparam int unsigned HostIdWidth   = 4;
  localparam int unsigned HostUserWidth = 1;

  typedef struct packed {
    logic [HostIdWidth-1:0]   id;
    logic [HostAddrWidth-1:0] addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
    logic                     lock;
    logic [3:0]               cache;
    logic [2:0]               prot;
    logic [3:0]               qos;
    logic [3:0]               region;
    logic [5:0]               atop;
    logic [HostUserWidth-1:0] user;
  } host_aw_chan_t;

  typedef struct packed {
    logic [HostDataWidth-1:0]   data;
    logic [HostDataWidth/8-1:0] strb;
    logic                       last;
    logic [HostUserWidth-1:0]   user;
  } host_w_chan_t;

  typedef struct packed {
    logic [HostIdWidth-1:0]   id;
    logic [1:0]               resp;
    logic [HostUserWidth-1:0] user;
  } host_b_chan_t;

  typedef struct packed {
    logic [HostIdWidth-1:0]   id;
    logic [HostAddrWidth-1:0] addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
    logic                     lock;
    logic [3:0]               cache;
    logic [2:0]               prot;
    logic [3:0]               qos;
    logic [3:0]               region;
    logic [HostUserWidth-1:0] user;
  } host_ar_chan_t;

  typedef struct packed {
    logic [HostIdWidth-1:0]   id;
    logic [HostDataWidth-1:0] data;
    logic [1:0]               resp;
    logic                     last;
    logic [HostUserWidth-1:0] user;
  } host_r_chan_t;

  typedef struct packed {
    host_aw_chan_t aw;
    logic          aw_valid;
    host_w_chan_t  w;
    logic          w_valid;
    logic          b_ready;
    host_ar_chan_t ar;
    logic          ar_valid;
    logic          r_ready;
  } host_req_t;

  typedef struct packed {
    logic         aw_ready;
    logic         ar_ready;
    logic         w_ready;
    logic         b_valid;
    host_b_chan_t b;
    logic         r_valid;
    host_r_chan_t r;
  } host_rsp_t;

endpackage

module picobello_tg_launcher #(
  parameter int unsigned AddrWidth    = 48,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned PollInterval = 64,
  parameter int unsigned PollTimeout  = 4096,
  parameter type axi_req_t = picobello_tg_launcher_pkg::host_req_t,
  parameter type axi_rsp_t = picobello_tg_launcher_pkg::host_rsp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [AddrWidth-1:0] cmd_tg_base_i,
  input  logic [31:0]          cmd_mem_base_i,
  input  logic [31:0]          cmd_traffic_dim_i,
  input  logic [31:0]          cmd_compute_dim_i,
  input  logic [31:0]          cmd_idx_i,
  output axi_req_t             axi_req_o,
  input  axi_rsp_t             axi_rsp_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [2:0]           err_step_o,
  output logic [15:0]          poll_count_o
);

  localparam logic [2:0] AxSize    = 3'($clog2(DataWidth / 8));
  localparam logic [1:0] BurstIncr = 2'b01;
  localparam logic [1:0] RespOkay  = 2'b00;
  localparam int unsigned WaitWidth = (PollInterval > 1) ? $clog2(PollInterval) : 1;

  typedef enum logic [2:0] {
    StIdle, StWrReq, StWrResp, StRdReq, StRdResp, StPollWait, StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [2:0]             step_q, step_d;
  logic [AddrWidth-1:0]   tg_base_q, tg_base_d;
  logic [31:0]            mem_base_q, mem_base_d;
  logic [31:0]            traffic_q, traffic_d;
  logic [31:0]            compute_q, compute_d;
  logic [31:0]            idx_q, idx_d;
  logic [31:0]            ctrl_q, ctrl_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic [15:0]            poll_cnt_q, poll_cnt_d;
  logic [WaitWidth-1:0]   wait_cnt_q, wait_cnt_d;
  logic                   err_q, err_d;
  logic [2:0]             err_step_q, err_step_d;

  logic [7:0]             offset;
  logic [31:0]            wdata;
  logic [AddrWidth-1:0]   addr;
  logic                   aw_fire, w_fire;

  // Whole response is folded here so unread fields (ids, user, upper data) do not warn.
  logic unused_rsp;
  assign unused_rsp = ^axi_rsp_i;

  // Register offset and write payload of the current step.
  always_comb begin
    offset = 8'h00;
    wdata  = 32'h0;
    case (step_q)
      3'd0: begin offset = 8'h10; wdata = mem_base_q; end
      3'd1: begin offset = 8'h1C; wdata = mem_base_q; end
      3'd2: begin offset = 8'h28; wdata = traffic_q;  end
      3'd3: begin offset = 8'h34; wdata = compute_q;  end
      3'd4: begin offset = 8'h40; wdata = idx_q;      end
      // Start bit plus the preserved ctrl[7] from the step-5 read.
      3'd6: wdata = (ctrl_q & 32'h80) | 32'h1;
      default: ;
    endcase
  end

  assign addr    = tg_base_q + AddrWidth'(offset);
  assign aw_fire = (state_q == StWrReq) && !aw_done_q && axi_rsp_i.aw_ready;
  assign w_fire  = (state_q == StWrReq) && !w_done_q && axi_rsp_i.w_ready;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    tg_base_d  = tg_base_q;
    mem_base_d = mem_base_q;
    traffic_d  = traffic_q;
    compute_d  = compute_q;
    idx_d      = idx_q;
    ctrl_d     = ctrl_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    poll_cnt_d = poll_cnt_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    err_step_d = err_step_q;
    axi_req_o  = '0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          tg_base_d  = cmd_tg_base_i;
          mem_base_d = cmd_mem_base_i;
          traffic_d  = cmd_traffic_dim_i;
          compute_d  = cmd_compute_dim_i;
          idx_d      = cmd_idx_i;
          step_d     = 3'd0;
          err_d      = 1'b0;
          err_step_d = 3'd0;
          poll_cnt_d = 16'd0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_d    = StWrReq;
        end
      end

      StWrReq: begin
        axi_req_o.aw_valid   = !aw_done_q;
        axi_req_o.aw.addr    = addr;
        axi_req_o.aw.size    = AxSize;
        axi_req_o.aw.burst   = BurstIncr;
        axi_req_o.w_valid    = !w_done_q;
        axi_req_o.w.data     = DataWidth'(wdata);
        axi_req_o.w.strb     = '1;
        axi_req_o.w.last     = 1'b1;
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StWrResp;
        end else begin
          aw_done_d = aw_done_q || aw_fire;
          w_done_d  = w_done_q || w_fire;
        end
      end

      StWrResp: begin
        axi_req_o.b_ready = 1'b1;
        if (axi_rsp_i.b_valid) begin
          if (axi_rsp_i.b.resp != RespOkay) begin
            err_d      = 1'b1;
            err_step_d = step_q;
            state_d    = StDone;
          end else if (step_q == 3'd6) begin
            step_d  = 3'd7;
            state_d = StRdReq;
          end else if (step_q == 3'd4) begin
            step_d  = 3'd5;
            state_d = StRdReq;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = StWrReq;
          end
        end
      end

      StRdReq: begin
        axi_req_o.ar_valid = 1'b1;
        axi_req_o.ar.addr  = addr;
        axi_req_o.ar.size  = AxSize;
        axi_req_o.ar.burst = BurstIncr;
        if (axi_rsp_i.ar_ready) begin
          state_d = StRdResp;
        end
      end

      StRdResp: begin
        axi_req_o.r_ready = 1'b1;
        if (axi_rsp_i.r_valid) begin
          if ((step_q == 3'd7) && (poll_cnt_q != 16'hFFFF)) begin
            poll_cnt_d = poll_cnt_q + 16'd1;
          end
          if (axi_rsp_i.r.resp != RespOkay) begin
            err_d      = 1'b1;
            err_step_d = step_q;
            state_d    = StDone;
          end else begin
            ctrl_d = axi_rsp_i.r.data[31:0];
            if (step_q == 3'd5) begin
              step_d  = 3'd6;
              state_d = StWrReq;
            end else if (axi_rsp_i.r.data[2]) begin
              state_d = StDone;
            end else begin
              wait_cnt_d = '0;
              state_d    = StPollWait;
            end
          end
        end
      end

      StPollWait: begin
        if ((PollTimeout != 0) && (32'(poll_cnt_q) >= PollTimeout)) begin
          err_d      = 1'b1;
          err_step_d = 3'd7;
          state_d    = StDone;
        end else if (wait_cnt_q == WaitWidth'(PollInterval - 1)) begin
          state_d = StRdReq;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      step_q     <= 3'd0;
      tg_base_q  <= '0;
      mem_base_q <= 32'h0;
      traffic_q  <= 32'h0;
      compute_q  <= 32'h0;
      idx_q      <= 32'h0;
      ctrl_q     <= 32'h0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      poll_cnt_q <= 16'd0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      err_step_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      tg_base_q  <= tg_base_d;
      mem_base_q <= mem_base_d;
      traffic_q  <= traffic_d;
      compute_q  <= compute_d;
      idx_q      <= idx_d;
      ctrl_q     <= ctrl_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      poll_cnt_q <= poll_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      err_step_q <= err_step_d;
    end
  end

  assign cmd_ready_o  = (state_q == StIdle);
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign err_o        = err_q;
  assign err_step_o   = err_step_q;
  assign poll_count_o = poll_cnt_q;

endmodule

// File: tb/tb_picobello_tg_launcher.sv
module tb_picobello_tg_launcher;
  import picobello_tg_launcher_pkg::*;

  localparam int unsigned PollInterval = 8;
  localparam int unsigned PollTimeout  = 5;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [47:0] cmd_tg_base = '0;
  logic [31:0] cmd_mem_base = '0, cmd_traffic_dim = '0, cmd_compute_dim = '0, cmd_idx = '0;
  host_req_t   req;
  host_rsp_t   rsp = '0;
  logic        busy, done, err;
  logic [2:0]  err_step;
  logic [15:0] poll_count;

  always #5 clk = ~clk;

  picobello_tg_launcher #(
    .AddrWidth   (48),
    .DataWidth   (64),
    .PollInterval(PollInterval),
    .PollTimeout (PollTimeout),
    .axi_req_t   (host_req_t),
    .axi_rsp_t   (host_rsp_t)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .cmd_valid_i      (cmd_valid),
    .cmd_ready_o      (cmd_ready),
    .cmd_tg_base_i    (cmd_tg_base),
    .cmd_mem_base_i   (cmd_mem_base),
    .cmd_traffic_dim_i(cmd_traffic_dim),
    .cmd_compute_dim_i(cmd_compute_dim),
    .cmd_idx_i        (cmd_idx),
    .axi_req_o        (req),
    .axi_rsp_i        (rsp),
    .busy_o           (busy),
    .done_o           (done),
    .err_o            (err),
    .err_step_o       (err_step),
    .poll_count_o     (poll_count)
  );

  typedef struct {
    bit          wr;
    logic [47:0] addr;
    logic [63:0] data;
    int          step;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Slave configuration
  bit          rnd = 0;
  bit          stall_step2 = 0;
  bit          idle_inject = 0;
  int          err_wr_step = -1;
  logic [31:0] ctrl_val = 32'h80;
  int          idle_on_poll = 1;

  // Slave state
  bit          aw_seen, w_seen, b_pend, b_up, r_pend, r_up;
  bit          aw_fp, w_fp, b_fp, ar_fp, r_fp;
  logic [47:0] aw_cap;
  logic [63:0] w_cap, r_data;
  logic [1:0]  b_resp;
  host_req_t   req_p;
  int          wr_done, polls_seen, cyc, last_ar, min_ar_gap;
  int          stab_err = 0, field_err = 0;

  // AXI slave: samples and drives on the falling edge; handshakes complete on the rising edge.
  always @(negedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp = '0;
      aw_seen = 0; w_seen = 0; b_pend = 0; b_up = 0; r_pend = 0; r_up = 0;
      aw_fp = 0; w_fp = 0; b_fp = 0; ar_fp = 0; r_fp = 0;
      req_p = '0; wr_done = 0; polls_seen = 0;
    end else begin
      host_aw_chan_t ea;
      host_w_chan_t  ew;
      host_ar_chan_t ear;
      exp_t          e;
      cyc++;
      if (req_p.aw_valid && !aw_fp && (!req.aw_valid || req.aw !== req_p.aw)) stab_err++;
      if (req_p.w_valid && !w_fp && (!req.w_valid || req.w !== req_p.w)) stab_err++;
      if (req_p.ar_valid && !ar_fp && (!req.ar_valid || req.ar !== req_p.ar)) stab_err++;
      if (b_fp) begin b_pend = 0; b_up = 0; end
      if (r_fp) begin r_pend = 0; r_up = 0; end
      if (aw_fp) begin
        aw_seen = 1; aw_cap = req_p.aw.addr;
        ea = '0; ea.addr = req_p.aw.addr; ea.size = 3'd3; ea.burst = 2'b01;
        if (req_p.aw !== ea) field_err++;
      end
      if (w_fp) begin
        w_seen = 1; w_cap = req_p.w.data;
        ew = '0; ew.data = req_p.w.data; ew.strb = '1; ew.last = 1'b1;
        if (req_p.w !== ew) field_err++;
      end
      if (aw_seen && w_seen) begin
        aw_seen = 0; w_seen = 0;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_write got addr=%h data=%h required none", aw_cap, w_cap);
          b_resp = 2'b00;
        end else begin
          e = sb.pop_front();
          if (!e.wr || aw_cap !== e.addr || w_cap !== e.data) begin
            failures++;
            $display("FAIL sb_write step=%0d got wr=1 addr=%h data=%h required wr=%0d addr=%h data=%h",
                     e.step, aw_cap, w_cap, e.wr, e.addr, e.data);
          end
          b_resp = (e.step == err_wr_step) ? 2'b10 : 2'b00;
        end
        wr_done++;
        b_pend = 1;
      end
      if (ar_fp) begin
        ear = '0; ear.addr = req_p.ar.addr; ear.size = 3'd3; ear.burst = 2'b01;
        if (req_p.ar !== ear) field_err++;
        checks++;
        e.step = 7;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_read got addr=%h required none", req_p.ar.addr);
        end else begin
          e = sb.pop_front();
          if (e.wr || req_p.ar.addr !== e.addr) begin
            failures++;
            $display("FAIL sb_read step=%0d got wr=0 addr=%h required wr=%0d addr=%h",
                     e.step, req_p.ar.addr, e.wr, e.addr);
          end
        end
        if (e.step == 5) begin
          r_data = {32'hDEAD_BEEF, ctrl_val};
        end else begin
          polls_seen++;
          if (polls_seen > 1 && (cyc - last_ar) < min_ar_gap) min_ar_gap = cyc - last_ar;
          last_ar = cyc;
          r_data = (idle_on_poll != 0 && polls_seen >= idle_on_poll) ? 64'h4 : 64'hFFFF_FFFF_0000_00FB;
        end
        r_pend = 1;
      end
      rsp = '0;
      if (stall_step2 && wr_done == 2) rsp.aw_ready = 1'b0;
      else if (rnd) rsp.aw_ready = w_seen && ($urandom % 2 == 1);
      else rsp.aw_ready = 1'b1;
      rsp.w_ready  = rnd ? ($urandom % 2 == 1) : 1'b1;
      rsp.ar_ready = rnd ? ($urandom % 3 == 0) : 1'b1;
      if (b_pend && !b_up && (!rnd || $urandom % 3 == 0)) b_up = 1;
      if (r_pend && !r_up && (!rnd || $urandom % 3 == 0)) r_up = 1;
      rsp.b_valid = b_up;
      rsp.b.resp  = b_resp;
      rsp.r_valid = r_up;
      rsp.r.data  = r_data;
      rsp.r.last  = 1'b1;
      if (idle_inject) begin rsp.b_valid = 1'b1; rsp.r_valid = 1'b1; end
      aw_fp = req.aw_valid && rsp.aw_ready;
      w_fp  = req.w_valid && rsp.w_ready;
      ar_fp = req.ar_valid && rsp.ar_ready;
      b_fp  = req.b_ready && rsp.b_valid;
      r_fp  = req.r_ready && rsp.r_valid;
      req_p = req;
    end
  end

  task automatic push_seq(input logic [47:0] base, input logic [31:0] mem, td, cd, idx,
                          input logic [31:0] ctrl, input int last_wr, input int npolls);
    logic [7:0]  offs [5];
    logic [31:0] dat  [5];
    exp_t        e;
    offs = '{8'h10, 8'h1C, 8'h28, 8'h34, 8'h40};
    dat  = '{mem, mem, td, cd, idx};
    for (int s = 0; s < 5; s++) begin
      if (s <= last_wr) begin
        e.wr = 1; e.addr = base + 48'(offs[s]); e.data = {32'h0, dat[s]}; e.step = s;
        sb.push_back(e);
      end
    end
    if (last_wr >= 5) begin
      e.wr = 0; e.addr = base; e.data = '0; e.step = 5; sb.push_back(e);
      e.wr = 1; e.data = {32'h0, (ctrl & 32'h80) | 32'h1}; e.step = 6; sb.push_back(e);
      for (int p = 0; p < npolls; p++) begin
        e.wr = 0; e.data = '0; e.step = 7; sb.push_back(e);
      end
    end
  endtask

  task automatic start_cmd(input logic [47:0] base, input logic [31:0] mem, td, cd, idx);
    wr_done = 0; polls_seen = 0; min_ar_gap = 1000000;
    @(negedge clk);
    cmd_tg_base = base; cmd_mem_base = mem; cmd_traffic_dim = td;
    cmd_compute_dim = cd; cmd_idx = idx; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n, output bit ok);
    n = 0; ok = 0;
    while (n < limit && !ok) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) ok = 1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL done_timeout got no done_o in %0d cycles required done_o", limit);
    end
  endtask

  task automatic check_status(input string name, input logic e_err, input logic [2:0] e_step,
                              input logic [15:0] e_polls);
    checks++;
    if (err !== e_err) begin
      failures++; $display("FAIL %s_err got %b required %b", name, err, e_err);
    end
    if (e_err) begin
      checks++;
      if (err_step !== e_step) begin
        failures++; $display("FAIL %s_err_step got %0d required %0d", name, err_step, e_step);
      end
    end
    checks++;
    if (poll_count !== e_polls) begin
      failures++; $display("FAIL %s_poll_count got %0d required %0d", name, poll_count, e_polls);
    end
    checks++;
    if (sb.size() != 0 || stab_err != 0 || field_err != 0) begin
      failures++;
      $display("FAIL %s_traffic got left=%0d unstable=%0d badfields=%0d required 0/0/0",
               name, sb.size(), stab_err, field_err);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if (req !== '0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        err_step !== 3'd0 || poll_count !== 16'd0) begin
      failures++;
      $display("FAIL %s got req_zero=%b ready=%b busy=%b done=%b err=%b step=%0d polls=%0d required 1/1/0/0/0/0/0",
               name, req === '0, cmd_ready, busy, done, err, err_step, poll_count);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset_held");
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset_released");
  endtask

  task automatic test_idle_resp();
    idle_inject = 1;
    repeat (3) begin
      @(negedge clk); #1;
      checks++;
      if (req.b_ready !== 1'b0 || req.r_ready !== 1'b0 || cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL idle_resp got b_ready=%b r_ready=%b cmd_ready=%b required 0/0/1",
                 req.b_ready, req.r_ready, cmd_ready);
      end
    end
    @(negedge clk);
    idle_inject = 0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    int n; bit ok;
    ctrl_val = 32'h80; idle_on_poll = 1;
    push_seq(48'hC000_0000, 32'hD000_0000, 32'h100, 32'h100, 32'h1, 32'h80, 6, 1);
    start_cmd(48'hC000_0000, 32'hD000_0000, 32'h100, 32'h100, 32'h1);
    checks++;
    if (req.aw_valid !== 1'b1 || req.w_valid !== 1'b1 || req.b_ready !== 1'b0 ||
        busy !== 1'b1 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL nominal_accept got aw_valid=%b w_valid=%b b_ready=%b busy=%b ready=%b required 1/1/0/1/0",
               req.aw_valid, req.w_valid, req.b_ready, busy, cmd_ready);
    end
    wait_done(200, n, ok);
    checks++;
    if (n > 17) begin
      failures++; $display("FAIL nominal_latency got %0d cycles required <=17", n);
    end
    check_status("nominal", 1'b0, 3'd0, 16'd1);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL nominal_pulse got done=%b busy=%b ready=%b err=%b required 0/0/1/0",
               done, busy, cmd_ready, err);
    end
  endtask

  task automatic test_ctrl_ff_poll4();
    int n; bit ok;
    ctrl_val = 32'hFF; idle_on_poll = 4;
    push_seq(48'hC004_0000, 32'h1234_5678, 32'h40, 32'h8, 32'h3, 32'hFF, 6, 4);
    start_cmd(48'hC004_0000, 32'h1234_5678, 32'h40, 32'h8, 32'h3);
    wait_done(400, n, ok);
    check_status("poll4", 1'b0, 3'd0, 16'd4);
    checks++;
    if (min_ar_gap < PollInterval) begin
      failures++; $display("FAIL poll4_gap got %0d required >=%0d", min_ar_gap, PollInterval);
    end
  endtask

  task automatic test_slverr();
    int n; bit ok;
    ctrl_val = 32'h80; idle_on_poll = 1; err_wr_step = 3;
    push_seq(48'hC008_0000, 32'hD000_1000, 32'h20, 32'h30, 32'h2, 32'h80, 3, 0);
    start_cmd(48'hC008_0000, 32'hD000_1000, 32'h20, 32'h30, 32'h2);
    wait_done(200, n, ok);
    repeat (20) @(negedge clk);
    check_status("slverr", 1'b1, 3'd3, 16'd0);
    checks++;
    if (wr_done != 4 || polls_seen != 0) begin
      failures++;
      $display("FAIL slverr_quiet got writes=%0d reads=%0d required 4/0", wr_done, polls_seen);
    end
    err_wr_step = -1;
  endtask

  task automatic test_timeout();
    int n; bit ok;
    // Base near the top of the address space so later offsets wrap.
    ctrl_val = 32'h0; idle_on_poll = 0;
    push_seq(48'hFFFF_FFFF_FFE0, 32'hA5A5_A5A5, 32'h7, 32'h9, 32'h5, 32'h0, 6, 5);
    start_cmd(48'hFFFF_FFFF_FFE0, 32'hA5A5_A5A5, 32'h7, 32'h9, 32'h5);
    wait_done(600, n, ok);
    repeat (20) @(negedge clk);
    check_status("timeout", 1'b1, 3'd7, 16'd5);
  endtask

  task automatic test_random();
    int n; bit ok;
    rnd = 1; ctrl_val = 32'h80; idle_on_poll = 1;
    push_seq(48'hC000_0000, 32'hD000_0000, 32'h100, 32'h100, 32'h1, 32'h80, 6, 1);
    start_cmd(48'hC000_0000, 32'hD000_0000, 32'h100, 32'h100, 32'h1);
    wait_done(2000, n, ok);
    check_status("random", 1'b0, 3'd0, 16'd1);
    rnd = 0;
  endtask

  task automatic test_reset_mid();
    int n; bit ok, hit;
    ctrl_val = 32'h80; idle_on_poll = 1; stall_step2 = 1;
    push_seq(48'hC000_0000, 32'hD000_0000, 32'h100, 32'h100, 32'h1, 32'h80, 6, 1);
    start_cmd(48'hC000_0000, 32'hD000_0000, 32'h100, 32'h100, 32'h1);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (wr_done == 2 && req.aw_valid === 1'b1) hit = 1;
    end
    checks++;
    if (!hit) begin
      failures++; $display("FAIL reset_mid_reach got no step-2 AW required step-2 AW pending");
    end
    #2 rst_ni = 1'b0;
    #1 check_reset_vals("reset_mid_async");
    repeat (2) @(negedge clk);
    sb.delete();
    stall_step2 = 0;
    #1 rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    push_seq(48'hC000_0000, 32'hD000_0000, 32'h100, 32'h100, 32'h1, 32'h80, 6, 1);
    start_cmd(48'hC000_0000, 32'hD000_0000, 32'h100, 32'h100, 32'h1);
    wait_done(200, n, ok);
    check_status("reset_mid_restart", 1'b0, 3'd0, 16'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_idle_resp();
    test_nominal();
    test_ctrl_ff_poll4();
    test_slverr();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
